// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the execute stage.
// Single-cycle logic/arith/compare ops complete in one cycle; MULTU (shift-add)
// and DIVU (restoring) iterate one bit per cycle and return a HI/LO pair.
// A start/busy/done handshake lets the controller stall while busy is high.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluresult,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             divzero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Controller states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;

  // Opcodes
  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSltu  = 4'b0011;
  localparam logic [3:0] OpXor   = 4'b0100;
  localparam logic [3:0] OpNor   = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSlt   = 4'b0111;
  localparam logic [3:0] OpMultu = 4'b1000;
  localparam logic [3:0] OpDivu  = 4'b1001;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Multiplicand (MULTU) or divisor (DIVU), latched at the accepting edge
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // MULTU: {partial product, multiplier}; DIVU: low half holds dividend/quotient
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               divzero_q, divzero_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_neg;
  logic [WIDTH:0]     div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;
  logic               last_iter;

  // Single-cycle result for the operands presented with start
  always_comb begin
    alu_res = '0;
    case (alucontrol)
      OpAnd:   alu_res = srcA & srcB;
      OpOr:    alu_res = srcA | srcB;
      OpAdd:   alu_res = srcA + srcB;
      OpSub:   alu_res = srcA - srcB;
      OpXor:   alu_res = srcA ^ srcB;
      OpNor:   alu_res = ~(srcA | srcB);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      default: alu_res = '0;
    endcase
  end

  // One iteration step of the shift-add multiplier and the restoring divider
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Remainder is always < divisor, so the shifted value fits in WIDTH+1 bits
    // and the extra top bit of the difference acts as the borrow.
    div_shift    = {rem_q, acc_q[WIDTH-1]};
    div_diff     = div_shift - {2'b00, opnd_q};
    div_neg      = div_diff[WIDTH+1];
    div_rem_next = div_neg ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
    div_quo_next = {acc_q[WIDTH-2:0], ~div_neg};

    last_iter = (cnt_q == CntW'(1));
  end

  // Controller and output next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    res_d     = res_q;
    hi_d      = hi_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (alucontrol == OpMultu) begin
            state_d = StMul;
            cnt_d   = CntW'(WIDTH);
            opnd_d  = srcA;
            acc_d   = {{WIDTH{1'b0}}, srcB};
          end else if (alucontrol == OpDivu) begin
            if (srcB == '0) begin
              // Divide by zero short-circuits with a defined result
              res_d     = '1;
              hi_d      = srcA;
              divzero_d = 1'b1;
              done_d    = 1'b1;
            end else begin
              state_d = StDiv;
              cnt_d   = CntW'(WIDTH);
              opnd_d  = srcB;
              acc_d   = {{WIDTH{1'b0}}, srcA};
              rem_d   = '0;
            end
          end else begin
            res_d     = alu_res;
            hi_d      = '0;
            divzero_d = 1'b0;
            done_d    = 1'b1;
          end
        end
      end

      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CntW'(1);
        if (last_iter) begin
          res_d     = mul_next[WIDTH-1:0];
          hi_d      = mul_next[2*WIDTH-1:WIDTH];
          divzero_d = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end

      StDiv: begin
        rem_d = div_rem_next;
        acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo_next};
        cnt_d = cnt_q - CntW'(1);
        if (last_iter) begin
          res_d     = div_quo_next;
          hi_d      = div_rem_next[WIDTH-1:0];
          divzero_d = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Zero flag follows the value actually being registered as the result
    zero_d = done_d ? (res_d == '0) : zero_q;
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      res_q     <= res_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign aluresult = res_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign divzero   = divzero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a driver pushes expected results computed from
// plain arithmetic; a monitor pops and compares on every done pulse and checks
// that outputs hold in all other cycles.
module tb_alu_mc;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dz;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alucontrol = 4'd0;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic         busy, done, zero, divzero;
  logic [W-1:0] aluresult, hi;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  exp_t sb[$];
  logic [W-1:0] last_res = '0;
  logic [W-1:0] last_hi = '0;
  logic         last_zero = 1'b0;
  logic         last_dz = 1'b0;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .srcA       (srcA),
    .srcB       (srcB),
    .busy       (busy),
    .done       (done),
    .aluresult  (aluresult),
    .hi         (hi),
    .zero       (zero),
    .divzero    (divzero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the opcode table
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t e);
    longint unsigned p;
    e.hi  = '0;
    e.dz  = 1'b0;
    e.due = 1;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0100: e.res = a ^ b;
      4'b0101: e.res = ~(a | b);
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0011: e.res = (a < b) ? 1 : 0;
      4'b1000: begin
        p     = longint'(a) * longint'(b);
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.due = W + 1;
      end
      4'b1001: begin
        if (b == 0) begin
          e.res = '1;
          e.hi  = a;
          e.dz  = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
          e.due = W + 1;
        end
      end
      default: e.res = '0;
    endcase
  endtask

  // Drive one request at a negedge once the DUT is idle
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    while (busy && guard < 200) begin
      start = 1'b0;
      guard++;
      @(negedge clk);
    end
    if (busy) chk("busy_timeout", 64'(busy), 64'd0);
    start = 1'b1;
    alucontrol = op;
    srcA = a;
    srcB = b;
    model(op, a, b, e);
    e.due = e.due + cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Monitor: compare on done, otherwise outputs must hold
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) continue;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 64'(aluresult), 64'(e.res));
          chk("hi", 64'(hi), 64'(e.hi));
          chk("zero", 64'(zero), 64'(e.res == '0));
          chk("divzero", 64'(divzero), 64'(e.dz));
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("busy_at_done", 64'(busy), 64'd0);
          last_res  = e.res;
          last_hi   = e.hi;
          last_zero = (e.res == '0);
          last_dz   = e.dz;
        end
      end else begin
        chk("hold_result", 64'(aluresult), 64'(last_res));
        chk("hold_hi", 64'(hi), 64'(last_hi));
        chk("hold_zero", 64'(zero), 64'(last_zero));
        chk("hold_divzero", 64'(divzero), 64'(last_dz));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int guard;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [3:0] ops[11];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0111, 4'b0011,
            4'b1000, 4'b1001, 4'b1111};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(aluresult), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_divzero", 64'(divzero), 64'd0);
    reset = 1'b0;

    // Reset in the middle of a MULTU discards it
    issue(4'b1000, 32'd7, 32'd9);
    idle(5);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(aluresult), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd0);
    chk("midrst_divzero", 64'(divzero), 64'd0);
    sb.delete();
    last_res = '0; last_hi = '0; last_zero = 1'b0; last_dz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(40);

    // Directed single-cycle ops and compares
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0110, 32'd5, 32'd3);
    issue(4'b0101, 32'd0, 32'd0);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0111, 32'd5, 32'd5);
    idle(2);

    // MULTU max*max with input churn while busy
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bc = 0;
    @(negedge clk);
    while (busy && bc < 100) begin
      bc++;
      srcA = $urandom;
      start = ~start;
      alucontrol = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_busy_cycles", 64'(bc), 64'(W));
    idle(2);

    // DIVU normal, divide by zero, then a clearing ADD
    issue(4'b1001, 32'd100, 32'd7);
    issue(4'b1001, 32'd100, 32'd0);
    issue(4'b0010, 32'd1, 32'd1);
    idle(2);

    // Back-to-back throughput, then a start in the MULTU done cycle
    issue(4'b0010, 32'd10, 32'd1);
    issue(4'b0010, 32'd20, 32'd2);
    issue(4'b0010, 32'd30, 32'd3);
    issue(4'b0010, 32'd40, 32'd4);
    issue(4'b1000, 32'd3, 32'd4);
    issue(4'b0001, 32'hF0, 32'h0F);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(10, 0)];
      if (op == 4'b1111) op = 4'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7, 0))
        0: a = '0;
        1: a = '1;
        2: b = '1;
        3: b = $urandom_range(15, 0);
        default: ;
      endcase
      if (op == 4'b1001 && $urandom_range(5, 0) == 0) b = '0;
      if ($urandom_range(3, 0) == 0) a = b;
      issue(op, a, b);
      if ($urandom_range(4, 0) == 0) idle($urandom_range(3, 1));
    end

    // Drain the scoreboard
    idle(1);
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the single-cycle MIPS ALU in the datapath execute stage. It adds a registered start/busy/done handshake and signed SLT. It also adds SLTU, XOR and NOR, a correct result-derived zero flag, and iterative unsigned multiply (MULTU) and divide (DIVU) that write a HI/LO result pair. The controller issues one operation at a time and stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width. Must be ≥ 4.
- `clk`  in  1: single clock. Rising edge active.
- `reset`  in  1: asynchronous, active-high. Clears all state immediately.
- `start`  in  1: request an operation. Sampled only when `busy`=0.
- `alucontrol`  in  4: operation code, captured with `start`.
- `srcA`  in  WIDTH: operand A, captured with `start`.
- `srcB`  in  WIDTH: operand B, captured with `start`.
- `busy`  out  1: multi-cycle operation in progress.
- `done`  out  1: one-cycle pulse; results valid from this cycle.
- `aluresult`  out  WIDTH: result, or LO for multiply/divide.
- `hi`  out  WIDTH: MULTU upper product or DIVU remainder; 0 for single-cycle ops.
- `zero`  out  1: `aluresult` == 0.
- `divzero`  out  1: last DIVU had `srcB` == 0.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (both modulo 2^WIDTH, no overflow trap).
  - 0100 XOR, 0101 NOR.
  - 0111 SLT: two's-complement signed compare, result 1 if A<B else 0.
  - 0011 SLTU: unsigned compare.
  - 1000 MULTU, 1001 DIVU.
  - All other codes: `aluresult`=0, `hi`=0, single-cycle.
- FSM states:
  - IDLE: `busy`=0. On `start`:
    - Single-cycle op: compute, register all outputs, stay IDLE.
    - MULTU/DIVU: latch operands, load counter=WIDTH, go to MUL or DIV.
  - MUL: shift-add, one bit per cycle. 2·WIDTH-bit accumulator. Counter decrements each edge; at 0, write `hi`/`aluresult` and go to IDLE.
  - DIV: restoring division, one quotient bit per cycle. Remainder WIDTH+1 bits. Same counter rule; quotient goes to `aluresult`, remainder to `hi`.
- DIVU by zero: no iteration, completes like a single-cycle op with `aluresult`=all-ones, `hi`=`srcA`, `divzero`=1.
- `divzero` is cleared on every other accepted op.
- `zero` is computed from the registered `aluresult` value. It is never forced by the opcode.
- Outputs hold their values until the next accepted operation completes.
- During MUL/DIV: `aluresult`, `hi`, `zero` and `divzero` keep the previous op's values.
- `start` while `busy`=1 is ignored. No queueing, no error flag.
- Operand and opcode changes during `busy` have no effect; operands are captured at the accepting edge.

## Timing
- Reset (async assert, any state): state=IDLE, counter=0, and `busy`=`done`=`zero`=`divzero`=0, `aluresult`=`hi`=0. Any in-flight op is discarded.
- Single-cycle op: `start` sampled at edge E0. Outputs and `done`=1 are valid in the cycle after E0 (latency 1). `busy` stays 0.
- MULTU/DIVU (non-zero divisor):
  - `busy` rises at E0 and stays high through edge E0+WIDTH.
  - At edge E0+WIDTH, results are written, `busy` goes to 0 and `done` goes to 1.
  - Latency is WIDTH+1 cycles from the `start` cycle.
- `done` is high for exactly one cycle per accepted op. It is 0 in every cycle without a completion.
- Back-to-back operation:
  - A `start` in the `done` cycle is accepted, because `busy`=0 by then.
  - Single-cycle ops therefore sustain one op per cycle, with `done` held high continuously.
- Counter wrap: the counter never underflows. It is only loaded from IDLE.

## Test plan
- Reset mid-op: MULTU with A=7, B=9; assert `reset` 5 cycles later → all outputs 0 immediately, and no `done` pulse follows.
- Single-cycle ops, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → `aluresult`=0, `zero`=1, `done` after 1 cycle.
  - SUB 5-3 → 2, `zero`=0.
  - NOR 0,0 → 0xFFFFFFFF.
- Compares:
  - SLT A=0xFFFFFFFF (-1), B=1 → 1.
  - SLTU on the same operands → 0.
  - SLT 5,5 → 0, `zero`=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - `busy` high for 32 cycles, `done` on cycle 33.
  - `hi`=0xFFFFFFFE, `aluresult`=0x00000001.
  - Toggling `srcA`/`start` during `busy` has no effect.
- DIVU:
  - 100÷7 → `aluresult`=14, `hi`=2, `divzero`=0, latency 33.
  - 100÷0 → `aluresult`=0xFFFFFFFF, `hi`=100, `divzero`=1, latency 1.
  - A following ADD 1+1 → `aluresult`=2, `divzero`=0.
- Back-to-back throughput: ADD issued every cycle for 4 cycles → 4 consecutive `done` cycles with the correct sums. Then MULTU 3×4 followed by an immediate `start` in its `done` cycle → the second op is accepted, and the first gives `aluresult`=12, `hi`=0.
